// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the matrix-keypad scan path: FSM state encoding,
// frame-result encoding and the active-low column strobe constants (the same
// 1110/1101/1011/0111 pattern the 7-segment digit enables use).
// -----------------------------------------------------------------------------
package keypad_pkg;

    localparam int KEY_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } scan_state_t;

    typedef enum logic [1:0] {
        FR_NONE   = 2'd0,
        FR_SINGLE = 2'd1,
        FR_MULTI  = 2'd2
    } frame_kind_t;

    typedef struct packed {
        frame_kind_t        kind;
        logic [KEY_W-1:0]   code;   // {col[1:0], row[1:0]}, meaningful for FR_SINGLE
    } frame_t;

    localparam frame_t FRAME_CLEAR = '{kind: FR_NONE, code: '0};

    localparam logic [3:0] COL_STROBE_0 = 4'b1110;
    localparam logic [3:0] COL_STROBE_1 = 4'b1101;
    localparam logic [3:0] COL_STROBE_2 = 4'b1011;
    localparam logic [3:0] COL_STROBE_3 = 4'b0111;

    function automatic logic [3:0] col_strobe(input logic [1:0] col);
        logic [3:0] s;
        case (col)
            2'd0:    s = COL_STROBE_0;
            2'd1:    s = COL_STROBE_1;
            2'd2:    s = COL_STROBE_2;
            default: s = COL_STROBE_3;
        endcase
        return s;
    endfunction

    // Index of the single set bit; only called with a one-hot argument.
    function automatic logic [1:0] row_index(input logic [3:0] row_low);
        logic [1:0] idx;
        case (row_low)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // Fold one column sample into the running frame classification.
    // A second low bit anywhere in the frame, in the same or another sample,
    // makes the whole frame MULTI.
    function automatic frame_t frame_merge(input frame_t     acc,
                                           input logic [1:0] col,
                                           input logic [3:0] row_low);
        frame_t res;
        logic   one_hot;
        res     = acc;
        one_hot = ((row_low & (row_low - 4'd1)) == 4'd0);
        if (row_low != 4'd0) begin
            if (one_hot && acc.kind == FR_NONE) begin
                res.kind = FR_SINGLE;
                res.code = {col, row_index(row_low)};
            end else begin
                res.kind = FR_MULTI;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for the asynchronous active-low keypad rows. Resets to
// all-ones so an idle (pulled-up) keypad is seen during and after reset.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   d    : asynchronous input bus
//   q    : synchronized output bus
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values and the two stages form a real shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
// 4x4 matrix-keypad scanner. Strobes one active-low column per SCAN_DIV
// cycles, samples the synchronized rows at the end of each column slot,
// classifies each 4-column frame, and debounces over DEBOUNCE_SCANS frames.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   row_n     : keypad rows, asynchronous, active-low
//   col_n     : column strobe, active-low one-hot
//   key_code  : debounced {col, row} of the accepted key, held after release
//   key_valid : one-cycle pulse when a press is accepted
//   key_down  : high while the accepted key is held
// -----------------------------------------------------------------------------
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       row_n,
    output logic [3:0]       col_n,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_down
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEBOUNCE_SCANS);

    // ---------------------------------------------------------------- rows
    logic [3:0] rows_s;

    sync_2ff #(.WIDTH(4)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_n),
        .q   (rows_s)
    );

    // ------------------------------------------------- divider and columns
    logic [DIV_W-1:0] div_q;
    logic [1:0]       col_q;
    logic             tc;
    logic             frame_done;
    frame_t           acc_q;
    frame_t           merged;

    assign tc         = (div_q == DIV_LAST);
    assign frame_done = tc && (col_q == 2'd3);
    // Includes the current column's sample, so at the column-3 TC this is the
    // complete frame result.
    assign merged     = frame_merge(acc_q, col_q, ~rows_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            col_q <= 2'd0;
            col_n <= COL_STROBE_0;
            acc_q <= FRAME_CLEAR;
        end else if (tc) begin
            div_q <= '0;
            col_q <= col_q + 2'd1;
            // Registered strobe so the keypad lines never see decode glitches.
            col_n <= col_strobe(col_q + 2'd1);
            acc_q <= frame_done ? FRAME_CLEAR : merged;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------ debounce
    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [KEY_W-1:0] cand_q, cand_d;
    logic [KEY_W-1:0] code_d;
    logic             valid_d, down_d;

    assign cnt_inc = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cand_q    <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            key_code  <= code_d;
            key_valid <= valid_d;
            key_down  <= down_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // left one unassigned would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        code_d  = key_code;
        valid_d = 1'b0;
        down_d  = key_down;

        if (frame_done) begin
            case (state_q)
                ST_IDLE: begin
                    if (merged.kind == FR_SINGLE) begin
                        cand_d = merged.code;
                        cnt_d  = CNT_ONE;
                        if (CNT_ONE == CNT_FULL) begin
                            code_d  = merged.code;
                            valid_d = 1'b1;
                            down_d  = 1'b1;
                            state_d = ST_PRESSED;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end
                end

                ST_DEBOUNCE: begin
                    if (merged.kind == FR_SINGLE && merged.code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_FULL) begin
                            code_d  = cand_q;
                            valid_d = 1'b1;
                            down_d  = 1'b1;
                            state_d = ST_PRESSED;
                        end
                    end else if (merged.kind == FR_SINGLE) begin
                        cand_d = merged.code;
                        cnt_d  = CNT_ONE;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end

                ST_PRESSED: begin
                    // Anything other than an empty frame keeps the key held;
                    // a second key never rolls over to a new code.
                    if (merged.kind == FR_NONE) begin
                        cnt_d = CNT_ONE;
                        if (CNT_ONE == CNT_FULL) begin
                            cnt_d   = '0;
                            down_d  = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end
                end

                ST_RELEASE: begin
                    if (merged.kind == FR_NONE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_FULL) begin
                            cnt_d   = '0;
                            down_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_PRESSED;
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan
// Self-checking bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_SCANS=2.
// A keypad model ties row_n to col_n through a mask of held keys; expected
// key codes go into a queue when a press is driven and are popped by the
// monitor on every key_valid pulse.
// -----------------------------------------------------------------------------
module tb_keypad_scan;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 2;
    localparam int FRAME          = 4 * SCAN_DIV;
    localparam int MAX_LAT        = (DEBOUNCE_SCANS + 1) * FRAME + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    logic [15:0] keys = 16'h0000;   // bit c*4+r = key at column c, row r held

    int vectors     = 0;
    int miscompares = 0;
    int valid_seen  = 0;
    logic [3:0] exp_q[$];
    logic prev_valid = 1'b0;

    keypad_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    // Passive keypad: a held key pulls its row low while its column is driven.
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col_n[c] && keys[c*4 + r]) row_n[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Step to just after the next falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (key_valid) begin
            valid_seen++;
            if (exp_q.size() > 0) begin
                check("key_code_at_valid", key_code, exp_q.pop_front());
                check("key_down_at_valid", key_down, 1'b1);
            end else begin
                check("spurious_valid", key_valid, 1'b0);
            end
            check("valid_pulse_width", prev_valid, 1'b0);
        end
        prev_valid = key_valid;
    end

    task automatic wait_valid(input int budget, output int lat);
        int start;
        start = valid_seen;
        lat   = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (valid_seen != start) begin
                lat = i;
                break;
            end
        end
    endtask

    // Return at the first cycle of column 0.
    task automatic align_frame();
        logic [3:0] prev;
        logic       found;
        found = 1'b0;
        prev  = col_n;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            tick();
            if (col_n == 4'b1110 && prev != 4'b1110) found = 1'b1;
            prev = col_n;
        end
        if (!found) check("frame_align_timeout", found, 1'b1);
    endtask

    initial begin
        int lat;
        int base;
        int fall;
        logic [3:0] exp_col;

        // ---- reset and idle scan
        repeat (3) tick();
        rst = 1'b0;
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_down", key_down, 1'b0);
        check("rst_key_code", key_code, 4'h0);
        for (int j = 0; j <= FRAME; j++) begin
            exp_col = 4'hF & ~(4'b0001 << ((j / SCAN_DIV) % 4));
            check($sformatf("idle_col_n_%0d", j), col_n, exp_col);
            if (j != FRAME) tick();
        end
        check("idle_key_down", key_down, 1'b0);

        // ---- press column 2 / row 1 -> code 9
        align_frame();
        keys = 16'h0200;
        exp_q.push_back(4'h9);
        wait_valid(MAX_LAT, lat);
        check("press9_seen", lat > 0, 1'b1);
        check("press9_latency", lat >= FRAME + 1 && lat <= MAX_LAT, 1'b1);
        tick();
        check("press9_key_down", key_down, 1'b1);
        check("press9_valid_low", key_valid, 1'b0);
        repeat (2 * FRAME) tick();
        check("hold9_key_down", key_down, 1'b1);

        // ---- one-frame release glitch while held
        base = valid_seen;
        align_frame();
        keys = 16'h0000;
        repeat (FRAME) tick();
        keys = 16'h0200;
        repeat (3 * FRAME) tick();
        check("glitch_key_down", key_down, 1'b1);
        check("glitch_no_valid", valid_seen - base, 0);

        // ---- real release
        keys = 16'h0000;
        fall = 0;
        for (int i = 1; i <= MAX_LAT; i++) begin
            tick();
            if (!key_down) begin
                fall = i;
                break;
            end
        end
        check("release_seen", fall > 0, 1'b1);
        check("release_not_early", fall > FRAME, 1'b1);
        check("release_code_held", key_code, 4'h9);
        check("release_no_valid", valid_seen - base, 0);

        // ---- key present for a single frame only (column 1 / row 3)
        base = valid_seen;
        align_frame();
        keys = 16'h0080;
        repeat (FRAME) tick();
        keys = 16'h0000;
        repeat (4 * FRAME) tick();
        check("short_no_valid", valid_seen - base, 0);
        check("short_key_down", key_down, 1'b0);
        check("short_code_held", key_code, 4'h9);

        // ---- two keys together: column 0 / row 0 and column 3 / row 2
        keys = 16'h4001;
        repeat (5 * FRAME) tick();
        check("multi_no_valid", valid_seen - base, 0);
        check("multi_key_down", key_down, 1'b0);

        // Drop column 0 / row 0: the remaining key must be accepted from IDLE.
        keys = 16'h4000;
        exp_q.push_back(4'hE);
        wait_valid(MAX_LAT, lat);
        check("single_after_multi_seen", lat > 0, 1'b1);
        check("single_after_multi_code", key_code, 4'hE);
        keys = 16'h0000;
        repeat (4 * FRAME) tick();
        check("single_after_multi_released", key_down, 1'b0);

        // ---- reset pulse during DEBOUNCE
        base = valid_seen;
        align_frame();
        keys = 16'h0200;
        repeat (FRAME + 2) tick();
        rst = 1'b1;
        tick();
        check("midrst_col_n", col_n, 4'b1110);
        check("midrst_key_valid", key_valid, 1'b0);
        check("midrst_key_down", key_down, 1'b0);
        check("midrst_key_code", key_code, 4'h0);
        rst = 1'b0;
        exp_q.push_back(4'h9);
        wait_valid(MAX_LAT, lat);
        // Two full fresh frames after reset release: decision visible at cycle 32.
        check("midrst_relatch_latency", lat, 2 * FRAME);
        check("midrst_no_extra_valid", valid_seen - base, 1);
        keys = 16'h0000;

        repeat (2) tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
